// File: rtl/mux_scan_pkg.sv
// rtl/mux_scan_pkg.sv - shared types, widths and scan index helpers for the mux scan serializer
package mux_scan_pkg;

    localparam int WORD_W = 8;
    localparam int SEL_W  = 3;

    localparam logic [SEL_W-1:0] SEL_ONE   = SEL_W'(1);
    localparam logic [SEL_W-1:0] LAST_SENT = SEL_W'(WORD_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        SCAN
    } state_e;

    function automatic logic [SEL_W-1:0] first_idx(input logic msb_first);
        return msb_first ? SEL_W'(WORD_W - 1) : '0;
    endfunction

    // Wraps modulo 8 in both directions; the wrap after the last bit is reloaded on the next load.
    function automatic logic [SEL_W-1:0] next_idx(input logic [SEL_W-1:0] cnt, input logic msb_first);
        return msb_first ? cnt - SEL_ONE : cnt + SEL_ONE;
    endfunction

endpackage

// File: rtl/scan_sel_counter.sv
// rtl/scan_sel_counter.sv - 3-bit scan counter driving the mux selects S0 (MSB) .. S2 (LSB)
module scan_sel_counter
    import mux_scan_pkg::*;
#(
    parameter int MSB_FIRST = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load_first,
    input  logic advance,
    output logic s0,
    output logic s1,
    output logic s2
);

    localparam logic MSB = (MSB_FIRST != 0);

    logic [SEL_W-1:0] cnt_q;
    logic [SEL_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_first) begin
            cnt_d = first_idx(MSB);
        end else if (advance) begin
            cnt_d = next_idx(cnt_q, MSB);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign s0 = cnt_q[2];
    assign s1 = cnt_q[1];
    assign s2 = cnt_q[0];

endmodule

// File: rtl/mux_scan_serializer.sv
// rtl/mux_scan_serializer.sv - loads a word onto the 8:1 mux inputs, scans the selects and serialises MUX_OUT
module mux_scan_serializer
    import mux_scan_pkg::*;
#(
    parameter int MSB_FIRST = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              LOAD_VALID,
    output logic              LOAD_READY,
    input  logic [WORD_W-1:0] DIN,
    output logic              I0,
    output logic              I1,
    output logic              I2,
    output logic              I3,
    output logic              I4,
    output logic              I5,
    output logic              I6,
    output logic              I7,
    output logic              S0,
    output logic              S1,
    output logic              S2,
    input  logic              MUX_OUT,
    output logic              SER_DATA,
    output logic              SER_VALID,
    input  logic              SER_READY,
    output logic              SER_LAST
);

    state_e            state_q, state_d;
    logic [WORD_W-1:0] d_q, d_d;
    logic [SEL_W-1:0]  sent_q, sent_d;
    logic              ser_data_q, ser_data_d;
    logic              ser_valid_q, ser_valid_d;
    logic              ser_last_q, ser_last_d;
    logic              cnt_load;
    logic              cnt_adv;

    scan_sel_counter #(
        .MSB_FIRST (MSB_FIRST)
    ) u_sel (
        .clk        (CLK),
        .rst        (RST),
        .load_first (cnt_load),
        .advance    (cnt_adv),
        .s0         (S0),
        .s1         (S1),
        .s2         (S2)
    );

    always_comb begin
        state_d     = state_q;
        d_d         = d_q;
        sent_d      = sent_q;
        ser_data_d  = ser_data_q;
        ser_valid_d = ser_valid_q;
        ser_last_d  = ser_last_q;
        cnt_load    = 1'b0;
        cnt_adv     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (LOAD_VALID) begin
                    d_d      = DIN;
                    cnt_load = 1'b1;
                    sent_d   = '0;
                    state_d  = FILL;
                end
            end
            FILL: begin
                // Selects already point at the first index, so MUX_OUT is the first bit.
                ser_data_d  = MUX_OUT;
                cnt_adv     = 1'b1;
                ser_valid_d = 1'b1;
                ser_last_d  = 1'b0;
                state_d     = SCAN;
            end
            SCAN: begin
                if (SER_READY) begin
                    if (sent_q == LAST_SENT) begin
                        ser_valid_d = 1'b0;
                        ser_last_d  = 1'b0;
                        state_d     = IDLE;
                    end else begin
                        ser_data_d = MUX_OUT;
                        cnt_adv    = 1'b1;
                        sent_d     = sent_q + SEL_ONE;
                        ser_last_d = ((sent_q + SEL_ONE) == LAST_SENT);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            d_q         <= '0;
            sent_q      <= '0;
            ser_data_q  <= 1'b0;
            ser_valid_q <= 1'b0;
            ser_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            d_q         <= d_d;
            sent_q      <= sent_d;
            ser_data_q  <= ser_data_d;
            ser_valid_q <= ser_valid_d;
            ser_last_q  <= ser_last_d;
        end
    end

    assign LOAD_READY = (state_q == IDLE);
    assign SER_DATA   = ser_data_q;
    assign SER_VALID  = ser_valid_q;
    assign SER_LAST   = ser_last_q;

    assign I0 = d_q[0];
    assign I1 = d_q[1];
    assign I2 = d_q[2];
    assign I3 = d_q[3];
    assign I4 = d_q[4];
    assign I5 = d_q[5];
    assign I6 = d_q[6];
    assign I7 = d_q[7];

endmodule

// File: tb/tb_mux_scan_serializer.sv
// tb/tb_mux_scan_serializer.sv - scoreboard bench with a behavioural 8:1 mux closing the select loop
module tb_mux_scan_serializer;

    logic       CLK = 1'b0;
    logic       RST;
    logic       LOAD_VALID;
    logic       SER_READY;
    logic [7:0] DIN;

    logic       load_ready, ser_data, ser_valid, ser_last, s0, s1, s2, mux_out;
    logic [7:0] i_m;
    logic [2:0] code_m;

    logic       l_load_ready, l_ser_data, l_ser_valid, l_ser_last, ls0, ls1, ls2, l_mux_out;
    logic [7:0] i_l;
    logic [2:0] code_l;

    logic [1:0] exp_q[$];
    logic [1:0] lexp_q[$];

    int total = 0;
    int bad   = 0;

    assign code_m    = {s0, s1, s2};
    assign mux_out   = i_m[code_m];
    assign code_l    = {ls0, ls1, ls2};
    assign l_mux_out = i_l[code_l];

    mux_scan_serializer #(.MSB_FIRST(1)) dut (
        .CLK(CLK), .RST(RST), .LOAD_VALID(LOAD_VALID), .LOAD_READY(load_ready), .DIN(DIN),
        .I0(i_m[0]), .I1(i_m[1]), .I2(i_m[2]), .I3(i_m[3]),
        .I4(i_m[4]), .I5(i_m[5]), .I6(i_m[6]), .I7(i_m[7]),
        .S0(s0), .S1(s1), .S2(s2), .MUX_OUT(mux_out),
        .SER_DATA(ser_data), .SER_VALID(ser_valid), .SER_READY(SER_READY), .SER_LAST(ser_last)
    );

    mux_scan_serializer #(.MSB_FIRST(0)) dut_lsb (
        .CLK(CLK), .RST(RST), .LOAD_VALID(LOAD_VALID), .LOAD_READY(l_load_ready), .DIN(DIN),
        .I0(i_l[0]), .I1(i_l[1]), .I2(i_l[2]), .I3(i_l[3]),
        .I4(i_l[4]), .I5(i_l[5]), .I6(i_l[6]), .I7(i_l[7]),
        .S0(ls0), .S1(ls1), .S2(ls2), .MUX_OUT(l_mux_out),
        .SER_DATA(l_ser_data), .SER_VALID(l_ser_valid), .SER_READY(SER_READY), .SER_LAST(l_ser_last)
    );

    initial forever #5 CLK = ~CLK;

    task automatic push_word(input logic [7:0] w, input bit msb);
        for (int k = 0; k < 8; k++) begin
            int idx;
            idx = msb ? 7 - k : k;
            if (msb) exp_q.push_back({w[idx], k == 7});
            else     lexp_q.push_back({w[idx], k == 7});
        end
    endtask

    task automatic load_word(input logic [7:0] w);
        int g;
        g = 0;
        while (!load_ready && g < 30) begin
            @(negedge CLK);
            g++;
        end
        LOAD_VALID = 1'b1;
        DIN        = w;
        @(negedge CLK);
        LOAD_VALID = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1; LOAD_VALID = 1'b0; SER_READY = 1'b0; DIN = 8'h00;
        repeat (2) @(negedge CLK);
        total++;
        if ({ser_valid, ser_last, ser_data} !== 3'b000) begin
            bad++; $display("FAIL reset_ser got v/l/d=%b%b%b want 000", ser_valid, ser_last, ser_data);
        end
        total++;
        if (load_ready !== 1'b1 || code_m !== 3'd0 || i_m !== 8'h00) begin
            bad++; $display("FAIL reset_state got ready=%b code=%0d i=%h want 1 0 00", load_ready, code_m, i_m);
        end
        total++;
        if ({l_ser_valid, l_ser_last, l_ser_data, l_load_ready} !== 4'b0001 || code_l !== 3'd0 || i_l !== 8'h00) begin
            bad++; $display("FAIL reset_lsb got v/l/d/r=%b%b%b%b code=%0d i=%h want 0001 0 00",
                            l_ser_valid, l_ser_last, l_ser_data, l_load_ready, code_l, i_l);
        end
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_msb_frame();
        int beat, edges;
        logic [1:0] it;
        beat = 0; edges = 0;
        SER_READY = 1'b1;
        load_word(8'hA5);
        push_word(8'hA5, 1);
        total++;
        if (ser_valid !== 1'b0 || code_m !== 3'd7 || load_ready !== 1'b0) begin
            bad++; $display("FAIL msb_fill got valid=%b code=%0d ready=%b want 0 7 0", ser_valid, code_m, load_ready);
        end
        while (exp_q.size() > 0 && edges < 20) begin
            @(negedge CLK); edges++;
            if (ser_valid) begin
                it = exp_q.pop_front();
                total++;
                if ({ser_data, ser_last} !== it || code_m !== 3'(6 - beat)) begin
                    bad++; $display("FAIL msb_bit%0d got d/l=%b%b code=%0d want %b code=%0d",
                                    beat, ser_data, ser_last, code_m, it, 3'(6 - beat));
                end
                beat++;
            end
        end
        @(negedge CLK); edges++;
        total++;
        if (exp_q.size() != 0 || edges != 9 || load_ready !== 1'b1 || ser_valid !== 1'b0) begin
            bad++; $display("FAIL msb_period got left=%0d edges=%0d ready=%b valid=%b want 0 9 1 0",
                            exp_q.size(), edges, load_ready, ser_valid);
        end
    endtask

    task automatic test_lsb_frame();
        int beat, edges;
        logic [1:0] it;
        beat = 0; edges = 0;
        SER_READY = 1'b1;
        load_word(8'h3C);
        push_word(8'h3C, 0);
        while (lexp_q.size() > 0 && edges < 20) begin
            @(negedge CLK); edges++;
            if (l_ser_valid) begin
                it = lexp_q.pop_front();
                total++;
                if ({l_ser_data, l_ser_last} !== it || code_l !== 3'(beat + 1)) begin
                    bad++; $display("FAIL lsb_bit%0d got d/l=%b%b code=%0d want %b code=%0d",
                                    beat, l_ser_data, l_ser_last, code_l, it, 3'(beat + 1));
                end
                beat++;
            end
        end
        total++;
        if (lexp_q.size() != 0) begin
            bad++; $display("FAIL lsb_drain got left=%0d want 0", lexp_q.size());
        end
    endtask

    task automatic test_backpressure();
        int beat, edges, st2, st7, holds;
        logic [1:0] it;
        beat = 0; edges = 0; st2 = 0; st7 = 0; holds = 0;
        SER_READY = 1'b1;
        load_word(8'hF0);
        push_word(8'hF0, 1);
        while (exp_q.size() > 0 && edges < 40) begin
            @(negedge CLK); edges++;
            SER_READY = 1'b1;
            if (ser_valid && beat == 2 && st2 < 3) begin SER_READY = 1'b0; st2++; end
            if (ser_valid && beat == 7 && st7 < 3) begin SER_READY = 1'b0; st7++; end
            if (ser_valid && SER_READY) begin
                it = exp_q.pop_front();
                total++;
                if ({ser_data, ser_last} !== it || code_m !== 3'(6 - beat)) begin
                    bad++; $display("FAIL bp_bit%0d got d/l=%b%b code=%0d want %b code=%0d",
                                    beat, ser_data, ser_last, code_m, it, 3'(6 - beat));
                end
                beat++;
            end else if (ser_valid) begin
                holds++;
                total++;
                if ({ser_data, ser_last} !== exp_q[0] || code_m !== 3'(6 - beat)) begin
                    bad++; $display("FAIL bp_hold%0d got d/l=%b%b code=%0d want %b code=%0d",
                                    beat, ser_data, ser_last, code_m, exp_q[0], 3'(6 - beat));
                end
            end
        end
        SER_READY = 1'b1;
        total++;
        if (exp_q.size() != 0 || holds != 6) begin
            bad++; $display("FAIL bp_drain got left=%0d holds=%0d want 0 6", exp_q.size(), holds);
        end
    endtask

    task automatic test_load_during_frame();
        int beat, edges;
        logic [1:0] it;
        beat = 0; edges = 0;
        SER_READY = 1'b1;
        load_word(8'h00);
        push_word(8'h00, 1);
        while (exp_q.size() > 0 && edges < 20) begin
            @(negedge CLK); edges++;
            LOAD_VALID = (beat >= 1 && beat <= 5);
            DIN        = 8'hFF;
            if (ser_valid) begin
                it = exp_q.pop_front();
                total++;
                if ({ser_data, ser_last} !== it || i_m !== 8'h00 || load_ready !== 1'b0) begin
                    bad++; $display("FAIL busy_bit%0d got d/l=%b%b i=%h ready=%b want %b 00 0",
                                    beat, ser_data, ser_last, i_m, load_ready, it);
                end
                beat++;
            end
        end
        LOAD_VALID = 1'b0;
        @(negedge CLK);
        total++;
        if (i_m !== 8'h00 || load_ready !== 1'b1) begin
            bad++; $display("FAIL busy_after got i=%h ready=%b want 00 1", i_m, load_ready);
        end
    endtask

    task automatic test_back_to_back();
        int edges, lasts, accept_edge;
        bit drop;
        logic [1:0] it;
        edges = 0; lasts = 0; accept_edge = -1; drop = 0;
        SER_READY  = 1'b1;
        LOAD_VALID = 1'b1;
        DIN        = 8'h81;
        push_word(8'h81, 1);
        push_word(8'h7E, 1);
        @(negedge CLK);
        DIN = 8'h7E;
        while (exp_q.size() > 0 && edges < 40) begin
            @(negedge CLK); edges++;
            if (drop) begin LOAD_VALID = 1'b0; drop = 0; end
            if (LOAD_VALID && load_ready) begin accept_edge = edges; drop = 1; end
            if (ser_valid) begin
                it = exp_q.pop_front();
                if (ser_last) lasts++;
                total++;
                if ({ser_data, ser_last} !== it) begin
                    bad++; $display("FAIL b2b_bit%0d got d/l=%b%b want %b", 15 - exp_q.size(), ser_data, ser_last, it);
                end
            end
        end
        LOAD_VALID = 1'b0;
        total++;
        if (accept_edge != 9 || lasts != 2 || exp_q.size() != 0) begin
            bad++; $display("FAIL b2b_frame got accept=%0d lasts=%0d left=%0d want 9 2 0", accept_edge, lasts, exp_q.size());
        end
    endtask

    task automatic test_reset_mid_frame();
        int beat, edges;
        logic [1:0] it;
        beat = 0; edges = 0;
        SER_READY = 1'b1;
        load_word(8'hAA);
        push_word(8'hAA, 1);
        while (beat < 4 && edges < 20) begin
            @(negedge CLK); edges++;
            if (ser_valid) begin
                it = exp_q.pop_front();
                total++;
                if ({ser_data, ser_last} !== it) begin
                    bad++; $display("FAIL rst_bit%0d got d/l=%b%b want %b", beat, ser_data, ser_last, it);
                end
                beat++;
            end
        end
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        total++;
        if ({ser_valid, ser_last, ser_data, load_ready} !== 4'b0001 || code_m !== 3'd0 || i_m !== 8'h00) begin
            bad++; $display("FAIL rst_mid got v/l/d/r=%b%b%b%b code=%0d i=%h want 0001 0 00",
                            ser_valid, ser_last, ser_data, load_ready, code_m, i_m);
        end
        RST = 1'b0;
        exp_q.delete();
        load_word(8'h55);
        push_word(8'h55, 1);
        edges = 0;
        while (exp_q.size() > 0 && edges < 20) begin
            @(negedge CLK); edges++;
            if (ser_valid) begin
                it = exp_q.pop_front();
                total++;
                if ({ser_data, ser_last} !== it) begin
                    bad++; $display("FAIL post_rst_bit%0d got d/l=%b%b want %b", 7 - exp_q.size(), ser_data, ser_last, it);
                end
            end
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++; $display("FAIL post_rst_drain got left=%0d want 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_msb_frame();
        test_lsb_frame();
        test_backpressure();
        test_load_during_frame();
        test_back_to_back();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
